// File: rtl/morse_encoder.sv
// morse_encoder: ASCII byte stream to Morse symbols.
// Emits per-element dot/dash strobes, letter/word gap strobes and a keying line
// timed in units of UNIT_CYCLES clocks. Define MORSE_DIGITS_EN to encode 0-9;
// otherwise digits are rejected like any other unsupported character.
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       key,
    output logic       dot,
    output logic       dash,
    output logic       lg,
    output logic       wg,
    output logic       busy,
    output logic       error
);

    // Counter must hold 7 units minus one (longest state, the word gap).
    localparam int unsigned CntW = $clog2(7 * UNIT_CYCLES);
    localparam logic [CntW-1:0] Cnt1 = CntW'(UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] Cnt3 = CntW'(3 * UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] Cnt7 = CntW'(7 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StOn,
        StEgap,
        StLgap,
        StWgap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      shift_q, shift_d;
    logic [2:0]      elem_q, elem_d;
    logic            key_q, key_d;
    logic            dot_q, dot_d;
    logic            dash_q, dash_d;
    logic            lg_q, lg_d;
    logic            wg_q, wg_d;
    logic            error_q, error_d;

    logic [7:0]      ch;
    logic [2:0]      rom_len;
    logic [4:0]      rom_pat;
    logic            cnt_zero;
    logic            accept;

    assign cnt_zero = (cnt_q == '0);
    // Ready also in the last letter-gap cycle so back-to-back letters get exactly 3 units.
    assign din_ready = (state_q == StIdle) || ((state_q == StLgap) && cnt_zero);
    assign accept    = din_valid && din_ready;

    // Fold case and look up length / left-justified pattern (1 = dash); len 0 = unsupported.
    always_comb begin
        ch = din;
        if (din >= 8'h61 && din <= 8'h7a) begin
            ch = din - 8'h20;
        end
        rom_len = 3'd0;
        rom_pat = 5'b00000;
        case (ch)
            8'h41: begin rom_len = 3'd2; rom_pat = 5'b01000; end // A .-
            8'h42: begin rom_len = 3'd4; rom_pat = 5'b10000; end // B -...
            8'h43: begin rom_len = 3'd4; rom_pat = 5'b10100; end // C -.-.
            8'h44: begin rom_len = 3'd3; rom_pat = 5'b10000; end // D -..
            8'h45: begin rom_len = 3'd1; rom_pat = 5'b00000; end // E .
            8'h46: begin rom_len = 3'd4; rom_pat = 5'b00100; end // F ..-.
            8'h47: begin rom_len = 3'd3; rom_pat = 5'b11000; end // G --.
            8'h48: begin rom_len = 3'd4; rom_pat = 5'b00000; end // H ....
            8'h49: begin rom_len = 3'd2; rom_pat = 5'b00000; end // I ..
            8'h4a: begin rom_len = 3'd4; rom_pat = 5'b01110; end // J .---
            8'h4b: begin rom_len = 3'd3; rom_pat = 5'b10100; end // K -.-
            8'h4c: begin rom_len = 3'd4; rom_pat = 5'b01000; end // L .-..
            8'h4d: begin rom_len = 3'd2; rom_pat = 5'b11000; end // M --
            8'h4e: begin rom_len = 3'd2; rom_pat = 5'b10000; end // N -.
            8'h4f: begin rom_len = 3'd3; rom_pat = 5'b11100; end // O ---
            8'h50: begin rom_len = 3'd4; rom_pat = 5'b01100; end // P .--.
            8'h51: begin rom_len = 3'd4; rom_pat = 5'b11010; end // Q --.-
            8'h52: begin rom_len = 3'd3; rom_pat = 5'b01000; end // R .-.
            8'h53: begin rom_len = 3'd3; rom_pat = 5'b00000; end // S ...
            8'h54: begin rom_len = 3'd1; rom_pat = 5'b10000; end // T -
            8'h55: begin rom_len = 3'd3; rom_pat = 5'b00100; end // U ..-
            8'h56: begin rom_len = 3'd4; rom_pat = 5'b00010; end // V ...-
            8'h57: begin rom_len = 3'd3; rom_pat = 5'b01100; end // W .--
            8'h58: begin rom_len = 3'd4; rom_pat = 5'b10010; end // X -..-
            8'h59: begin rom_len = 3'd4; rom_pat = 5'b10110; end // Y -.--
            8'h5a: begin rom_len = 3'd4; rom_pat = 5'b11000; end // Z --..
`ifdef MORSE_DIGITS_EN
            8'h30: begin rom_len = 3'd5; rom_pat = 5'b11111; end // 0
            8'h31: begin rom_len = 3'd5; rom_pat = 5'b01111; end // 1
            8'h32: begin rom_len = 3'd5; rom_pat = 5'b00111; end // 2
            8'h33: begin rom_len = 3'd5; rom_pat = 5'b00011; end // 3
            8'h34: begin rom_len = 3'd5; rom_pat = 5'b00001; end // 4
            8'h35: begin rom_len = 3'd5; rom_pat = 5'b00000; end // 5
            8'h36: begin rom_len = 3'd5; rom_pat = 5'b10000; end // 6
            8'h37: begin rom_len = 3'd5; rom_pat = 5'b11000; end // 7
            8'h38: begin rom_len = 3'd5; rom_pat = 5'b11100; end // 8
            8'h39: begin rom_len = 3'd5; rom_pat = 5'b11110; end // 9
`else
`endif
            default: begin rom_len = 3'd0; rom_pat = 5'b00000; end
        endcase
    end

    // Next-state, duration counter and registered strobe/key values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CntW'(1);
        shift_d = shift_q;
        elem_d  = elem_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        lg_d    = 1'b0;
        wg_d    = 1'b0;
        error_d = 1'b0;

        case (state_q)
            StOn: begin
                if (cnt_zero) begin
                    if (elem_q != 3'd0) begin
                        state_d = StEgap;
                        cnt_d   = Cnt1;
                        shift_d = shift_q << 1;
                        elem_d  = elem_q - 3'd1;
                    end else begin
                        state_d = StLgap;
                        cnt_d   = Cnt3;
                        lg_d    = 1'b1;
                    end
                end
            end
            StEgap: begin
                if (cnt_zero) begin
                    state_d = StOn;
                    cnt_d   = shift_q[4] ? Cnt3 : Cnt1;
                    dot_d   = ~shift_q[4];
                    dash_d  = shift_q[4];
                end
            end
            StLgap: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            StWgap: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        // Acceptance happens only in IDLE or the final letter-gap cycle.
        if (accept) begin
            if (rom_len != 3'd0) begin
                state_d = StOn;
                shift_d = rom_pat;
                elem_d  = rom_len - 3'd1;
                cnt_d   = rom_pat[4] ? Cnt3 : Cnt1;
                dot_d   = ~rom_pat[4];
                dash_d  = rom_pat[4];
            end else if (ch == 8'h20) begin
                state_d = StWgap;
                cnt_d   = Cnt7;
                wg_d    = 1'b1;
            end else begin
                state_d = StIdle;
                error_d = 1'b1;
            end
        end

        key_d = (state_d == StOn);
    end

    // State and output registers; reset abandons any character in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= 5'b00000;
            elem_q  <= 3'd0;
            key_q   <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            lg_q    <= 1'b0;
            wg_q    <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            elem_q  <= elem_d;
            key_q   <= key_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            lg_q    <= lg_d;
            wg_q    <= wg_d;
            error_q <= error_d;
        end
    end

    assign key   = key_q;
    assign dot   = dot_q;
    assign dash  = dash_q;
    assign lg    = lg_q;
    assign wg    = wg_q;
    assign error = error_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed characters, an event scoreboard filled from
// a Morse-string model and drained by a per-cycle monitor.
module tb_morse_encoder;

    localparam int unsigned U = 2;

    localparam int EvRdyDn = 0;
    localparam int EvRdyUp = 1;
    localparam int EvKeyUp = 2;
    localparam int EvKeyDn = 3;
    localparam int EvDot   = 4;
    localparam int EvDash  = 5;
    localparam int EvLg    = 6;
    localparam int EvWg    = 7;
    localparam int EvErr   = 8;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       key;
    logic       dot;
    logic       dash;
    logic       lg;
    logic       wg;
    logic       busy;
    logic       error;

    ev_t  sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_key = 1'b0;
    logic prev_ready = 1'b1;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .key       (key),
        .dot       (dot),
        .dash      (dash),
        .lg        (lg),
        .wg        (wg),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        sbq.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (sbq.size() == 0) begin
            chk($sformatf("unexpected_event_kind%0d_cyc%0d", kind, cyc), kind, -1);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("event_kind_cyc%0d", cyc), kind, e.kind);
            chk($sformatf("event_cycle_kind%0d", e.kind), cyc, e.at);
        end
    endtask

    // Fixed per-cycle order: ready, key, dot, dash, lg, wg, error.
    task automatic monitor();
        if (din_ready !== prev_ready) expect_ev(din_ready ? EvRdyUp : EvRdyDn);
        if (key !== prev_key) expect_ev(key ? EvKeyUp : EvKeyDn);
        if (dot === 1'b1) expect_ev(EvDot);
        if (dash === 1'b1) expect_ev(EvDash);
        if (lg === 1'b1) expect_ev(EvLg);
        if (wg === 1'b1) expect_ev(EvWg);
        if (error === 1'b1) expect_ev(EvErr);
        prev_ready = din_ready;
        prev_key   = key;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    function automatic string code_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7a) u = c - 8'd32;
        case (u)
            8'h41: return ".-";
            8'h45: return ".";
            8'h4b: return "-.-";
            8'h51: return "--.-";
            8'h54: return "-";
            8'h5a: return "--..";
`ifdef MORSE_DIGITS_EN
            8'h30: return "-----";
            8'h35: return ".....";
            8'h39: return "----.";
`endif
            default: return "";
        endcase
    endfunction

    // Expected events for a character transferred at the edge before cycle 'base'.
    task automatic model(input logic [7:0] c, input int base);
        string s;
        int    t;
        bit    is_dash;
        s = code_of(c);
        if (c == 8'h20) begin
            push(EvRdyDn, base);
            push(EvWg, base);
            push(EvRdyUp, base + 7 * U);
        end else if (s.len() == 0) begin
            push(EvErr, base);
        end else begin
            t = base;
            push(EvRdyDn, t);
            for (int i = 0; i < s.len(); i++) begin
                is_dash = (s[i] == 8'h2d);
                push(EvKeyUp, t);
                push(is_dash ? EvDash : EvDot, t);
                t += (is_dash ? 3 : 1) * U;
                push(EvKeyDn, t);
                if (i < s.len() - 1) begin
                    t += U;
                end else begin
                    push(EvLg, t);
                    push(EvRdyUp, t + 3 * U - 1);
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        din = c;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (din_ready !== 1'b1) chk("ready_timeout", din_ready, 1);
        model(c, cyc + 1);
        tick();
        din_valid = 1'b0;
        din = 8'h45;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_key"}, key, 0);
        chk({pfx, "_dot"}, dot, 0);
        chk({pfx, "_dash"}, dash, 0);
        chk({pfx, "_lg"}, lg, 0);
        chk({pfx, "_wg"}, wg, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_error"}, error, 0);
        chk({pfx, "_din_ready"}, din_ready, 1);
    endtask

    initial begin
        #2;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(8'h45);                 // E
        chk("busy_during_E", busy, 1);
        drain();

        send(8'h61);                 // a, then T back-to-back
        send(8'h54);
        drain();

        send(8'h20);                 // space
        drain();

        send(8'h23);                 // '#'
        repeat (4) tick();
        drain();

        send(8'h35);                 // '5'
        drain();

        send(8'h4b);                 // K then z back-to-back
        send(8'h7a);
        drain();

        // Q, reset during its second dash.
        send(8'h51);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sbq.delete();
        prev_key   = 1'b0;
        prev_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h45);                 // E after reset
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Converts a stream of ASCII characters into Morse symbols. It is the transmit counterpart of the Morse decoder. Each accepted character drives two things: per-element `dot`/`dash` strobes with `lg`/`wg` gap strobes that the decoder can consume directly, and a `key` line timed in standard Morse units for an external keyer or sounder. It sits between a byte source (host or FIFO, valid/ready) and the Morse link.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse time unit; legal range 1 to 1024.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 8: ASCII character.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: encoder can accept a character; transfer occurs when `din_valid && din_ready` at a rising edge.
- `key` out 1: keying line; high during dot or dash elements.
- `dot` out 1: one-cycle strobe in the first cycle of each dot element.
- `dash` out 1: one-cycle strobe in the first cycle of each dash element.
- `lg` out 1: one-cycle strobe in the first cycle of each letter gap.
- `wg` out 1: one-cycle strobe in the first cycle of each word gap.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `error` out 1: one-cycle strobe when an unsupported character is accepted.

## Operation
- Supported characters:
  - `A`–`Z` (0x41–0x5A).
  - `a`–`z`, folded to upper case.
  - Space (0x20).
  - Digits `0`–`9`, only with the configuration macro defined.
- Lookup ROM gives `len` (1–5) and `pattern` (5 bits, MSB-first, 1 = dash, 0 = dot). Example: A = len 2, pattern `01`.
- FSM states:
  - IDLE: `din_ready` = 1.
    - Letter accepted: load shift register and element counter, go to ON.
    - Space accepted: go to WGAP.
    - Unsupported character accepted: pulse `error`, stay in IDLE.
  - ON: `key` = 1.
    - Duration is 1 unit for a dot, 3 units for a dash.
    - At expiry: go to EGAP if elements remain, else LGAP.
  - EGAP: `key` = 0 for 1 unit; then ON with the next element.
  - LGAP: `key` = 0 for 3 units; `lg` in the first cycle; then IDLE.
  - WGAP: `key` = 0 for 7 units; `wg` in the first cycle; then IDLE.
- Duration counter:
  - Wide enough for 7×`UNIT_CYCLES`−1.
  - Loaded with N×`UNIT_CYCLES`−1 on state entry; counts down; the state expires at 0.
- `din_valid` is ignored while `din_ready` = 0. `din` is sampled only at the transfer edge.
- Element strobes (`dot`, `dash`) are mutually exclusive. `dot`/`dash` never coincide with `lg`/`wg`.

## Timing
- Reset values:
  - `key`, `dot`, `dash`, `lg`, `wg`, `busy`, `error` = 0.
  - `din_ready` = 1.
  - FSM = IDLE.
- Transfer edge T:
  - `key` and the first `dot`/`dash` strobe are registered at T, so they are visible in cycle T+1.
  - `din_ready` = 0 from T+1.
- Letter occupancy from T to `din_ready` = 1 is exactly (Σ element units + (len−1) + 3) × `UNIT_CYCLES` cycles.
  - E at `UNIT_CYCLES` = 4 gives 16 cycles.
  - A gives (1+3+1+3) × 4 = 32 cycles.
- Space: `din_ready` low for 7×`UNIT_CYCLES` cycles.
- Unsupported character: `error` high in cycle T+1 only; `din_ready` stays 1; no `key` or strobe activity.
- Back-to-back: a new character may transfer on the first edge `din_ready` = 1. There is no extra idle cycle, so the letter gap is exactly 3 units.
- Reset asserted mid-character: all outputs go immediately to reset values, and the character is abandoned. After release the first transfer behaves as from cold.
- `UNIT_CYCLES` = 1: dot `key` high for exactly 1 cycle; strobes still one cycle.

## Configuration
- `MORSE_DIGITS_EN`:
  - Defined: digits `0`–`9` are encoded as 5-element codes. Example: 0 = `11111`, 5 = `00000`, 9 = `11110`.
  - Undefined: digit ROM entries are omitted, and digits are treated as unsupported (`error` pulse, no output).

## Test plan
- `UNIT_CYCLES` = 2, send `E` → `dot` at T+1; `key` high 2 cycles; `lg` at T+3; `key` low 6 cycles; `din_ready` high again after 8 cycles.
- Send `a` then `T` back-to-back:
  - `a`: `dot`, `key` 2 cycles, gap 2, then `dash`, `key` 6 cycles, `lg`.
  - `T`: accepted on the first ready edge; its `dash` strobe follows exactly 6 `key`-low cycles after the last `key` high of `a`.
- Send 0x20 → `wg` at T+1; `key` low; `din_ready` low 14 cycles; no `dot`/`dash`/`lg`.
- Send `#` (0x23) → `error` at T+1 for one cycle; `din_ready` never drops; `key` stays 0.
- Send `5`:
  - With `MORSE_DIGITS_EN`: five `dot` strobes, 9 units of `key` activity, then `lg`.
  - Without it: `error` only.
- Send `Q` and assert `rst_n` = 0 during the second `dash` → all outputs 0 and `din_ready` = 1 immediately. After release, `E` encodes correctly with standard timing.
